controle_multiciclo: RTL and testbench

//  Multicycle MIPS control FSM. Sequences the register file, ALU, PC and the shared instruction/data

---
 rtl/controle_multiciclo_pkg.sv | 136 +++++++++++++
 rtl/controle_multiciclo_if.sv | 37 +++
 rtl/controle_multiciclo.sv | 82 ++++++++
 tb/tb_controle_multiciclo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, state codes,
// datapath mux codes and the Moore output table.
package controle_multiciclo_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG_B   = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11,
    ST_ILLEGAL   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       excecao;
  } ctrl_t;

  // Pure Moore outputs; the handshake-dependent terms are added by the controller.
  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
      end
      ST_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      ST_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG_B;
        c.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      ST_ADDI_WB: begin
        c.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REG_B;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      ST_ILLEGAL: begin
        c.excecao = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic state_t decode_opcode(input logic [5:0] op);
    case (op)
      OP_RTYPE:     return ST_R_EXEC;
      OP_LW, OP_SW: return ST_MEM_ADDR;
      OP_BEQ:       return ST_BRANCH;
      OP_J:         return ST_JUMP;
      OP_ADDI:      return ST_ADDI_EXEC;
      default:      return ST_ILLEGAL;
    endcase
  endfunction

  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
  endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Controller <-> datapath/memory signal bundle. The controller is the master:
// it consumes Opcode and Mem_Ready and drives every control line.
interface controle_multiciclo_if;
  logic [5:0] Opcode;
  logic       Mem_Ready;
  logic       PC_Write;
  logic       PC_Write_Cond;
  logic       IorD;
  logic       Mem_Read;
  logic       Mem_Write;
  logic       IR_Write;
  logic       Mem_to_Reg;
  logic       Reg_Write;
  logic       Reg_Dst;
  logic       ALU_Src_A;
  logic [1:0] ALU_Src_B;
  logic [1:0] ALU_Op;
  logic [1:0] PC_Source;
  logic       Excecao;
  logic [3:0] Estado;

  // Memory handshake: a request (Mem_Read/Mem_Write) is held while the FSM sits in
  // a memory state; the access completes in the cycle Mem_Ready is sampled high.
  modport master (
    input  Opcode, Mem_Ready,
    output PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, IR_Write,
           Mem_to_Reg, Reg_Write, Reg_Dst, ALU_Src_A, ALU_Src_B, ALU_Op,
           PC_Source, Excecao, Estado
  );

  modport slave (
    output Opcode, Mem_Ready,
    input  PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, IR_Write,
           Mem_to_Reg, Reg_Write, Reg_Dst, ALU_Src_A, ALU_Src_B, ALU_Op,
           PC_Source, Excecao, Estado
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control FSM: one state register, one memory wait counter with
// timeout abort, and a state-decoded output table.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 15,
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  controle_multiciclo_if.master ctl
);

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       mem_rdy;
  logic       timeout;
  ctrl_t      ctrl;

  assign mem_rdy = USE_MEM_READY ? ctl.Mem_Ready : 1'b1;

  // A ready in the timeout cycle still counts as completion.
  assign timeout = is_mem_state(state) && !mem_rdy && (wait_cnt == TIMEOUT_C);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:     if (mem_rdy) state_nxt = ST_DECODE;
      ST_DECODE:    state_nxt = decode_opcode(ctl.Opcode);
      ST_MEM_ADDR:  state_nxt = (ctl.Opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (mem_rdy) state_nxt = ST_MEM_WB;
      ST_MEM_WRITE: if (mem_rdy) state_nxt = ST_FETCH;
      ST_R_EXEC:    state_nxt = ST_R_WB;
      ST_ADDI_EXEC: state_nxt = ST_ADDI_WB;
      default:      state_nxt = ST_FETCH;
    endcase
    if (timeout) state_nxt = ST_FETCH;
  end

  // The counter restarts on every state change and on a timeout, which can
  // leave the FSM in FETCH and must still give the next fetch a fresh budget.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= ST_FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (timeout || (state_nxt != state)) wait_cnt <= 8'd0;
      else if (is_mem_state(state) && !mem_rdy) wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    ctrl = decode_state(state);
    if (state == ST_FETCH) begin
      ctrl.ir_write = mem_rdy;
      ctrl.pc_write = mem_rdy;
    end
    if (timeout) ctrl.excecao = 1'b1;
    if (Reset) ctrl = '0;
  end

  assign ctl.PC_Write      = ctrl.pc_write;
  assign ctl.PC_Write_Cond = ctrl.pc_write_cond;
  assign ctl.IorD          = ctrl.iord;
  assign ctl.Mem_Read      = ctrl.mem_read;
  assign ctl.Mem_Write     = ctrl.mem_write;
  assign ctl.IR_Write      = ctrl.ir_write;
  assign ctl.Mem_to_Reg    = ctrl.mem_to_reg;
  assign ctl.Reg_Write     = ctrl.reg_write;
  assign ctl.Reg_Dst       = ctrl.reg_dst;
  assign ctl.ALU_Src_A     = ctrl.alu_src_a;
  assign ctl.ALU_Src_B     = ctrl.alu_src_b;
  assign ctl.ALU_Op        = ctrl.alu_op;
  assign ctl.PC_Source     = ctrl.pc_source;
  assign ctl.Excecao       = ctrl.excecao;
  assign ctl.Estado        = Reset ? ST_FETCH : state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: builds the expected per-cycle control words of
// each instruction from its phase list and compares them cycle by cycle.
module tb_controle_multiciclo;
  import controle_multiciclo_pkg::*;

  localparam int W   = 18;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  controle_multiciclo_if bus ();

  controle_multiciclo #(.MEM_TIMEOUT(TMO), .USE_MEM_READY(1'b1)) dut (
    .Clock (clk),
    .Reset (rst),
    .ctl   (bus)
  );

  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];
  int checks = 0;
  int errors = 0;

  logic [W-1:0] w_fetch_wait, w_fetch_done, w_fetch_to, w_decode, w_mem_addr;
  logic [W-1:0] w_mem_read, w_mem_read_to, w_mem_wb, w_mem_write, w_mem_write_to;
  logic [W-1:0] w_r_exec, w_r_wb, w_addi_exec, w_addi_wb, w_branch, w_jump, w_illegal;

  function automatic logic [W-1:0] mk(input logic pcw, input logic pcwc, input logic iord,
                                      input logic mr, input logic mw, input logic irw,
                                      input logic m2r, input logic rw, input logic rd,
                                      input logic sa, input logic [1:0] sb, input logic [1:0] op,
                                      input logic [1:0] ps, input logic ex);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, sa, sb, op, ps, ex};
  endfunction

  function automatic logic [W-1:0] obs_word();
    return {bus.PC_Write, bus.PC_Write_Cond, bus.IorD, bus.Mem_Read, bus.Mem_Write,
            bus.IR_Write, bus.Mem_to_Reg, bus.Reg_Write, bus.Reg_Dst, bus.ALU_Src_A,
            bus.ALU_Src_B, bus.ALU_Op, bus.PC_Source, bus.Excecao};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // waits > TMO models a memory that never answers: TMO plain waits, then the abort cycle.
  task automatic push_mem(input int waits, input logic [W-1:0] done_w, input logic [W-1:0] wait_w,
                          input logic [W-1:0] to_w, output bit ok);
    if (waits > TMO) begin
      for (int i = 0; i < TMO; i++) begin exp_q.push_back(wait_w); rdy_q.push_back(1'b0); end
      exp_q.push_back(to_w); rdy_q.push_back(1'b0);
      ok = 1'b0;
    end else begin
      for (int i = 0; i < waits; i++) begin exp_q.push_back(wait_w); rdy_q.push_back(1'b0); end
      exp_q.push_back(done_w); rdy_q.push_back(1'b1);
      ok = 1'b1;
    end
  endtask

  task automatic push_step(input logic [W-1:0] w);
    exp_q.push_back(w);
    rdy_q.push_back(1'b1);
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input int wf, input int wm,
                           input int rst_at, input int rst_len);
    bit ok;
    int n;
    int decode_idx;
    exp_q.delete();
    rdy_q.delete();
    push_mem(wf, w_fetch_done, w_fetch_wait, w_fetch_to, ok);
    decode_idx = ok ? wf + 1 : -1;
    if (ok) begin
      push_step(w_decode);
      case (op)
        OP_RTYPE: begin push_step(w_r_exec); push_step(w_r_wb); end
        OP_LW: begin
          push_step(w_mem_addr);
          push_mem(wm, w_mem_read, w_mem_read, w_mem_read_to, ok);
          if (ok) push_step(w_mem_wb);
        end
        OP_SW: begin
          push_step(w_mem_addr);
          push_mem(wm, w_mem_write, w_mem_write, w_mem_write_to, ok);
        end
        OP_BEQ:  push_step(w_branch);
        OP_J:    push_step(w_jump);
        OP_ADDI: begin push_step(w_addi_exec); push_step(w_addi_wb); end
        default: push_step(w_illegal);
      endcase
    end
    bus.Opcode = op;
    n = 0;
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic         r;
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      @(negedge clk);
      rst = 1'b0;
      if (n == rst_at) begin
        for (int k = 0; k < rst_len; k++) begin
          if (k > 0) @(negedge clk);
          rst = 1'b1;
          bus.Mem_Ready = 1'b1;
          #1;
          chk($sformatf("%s_reset_outs%0d", name, k), 32'(obs_word()), 32'd0);
          chk($sformatf("%s_reset_estado%0d", name, k), 32'(bus.Estado), 32'(ST_FETCH));
        end
        return;
      end
      bus.Mem_Ready = r;
      #1;
      if (n == 0) chk($sformatf("%s_start_fetch", name), 32'(bus.Estado), 32'(ST_FETCH));
      if (n == decode_idx) chk($sformatf("%s_decode", name), 32'(bus.Estado), 32'(ST_DECODE));
      chk($sformatf("%s_cyc%0d", name, n), 32'(obs_word()), 32'(e));
      chk($sformatf("%s_rw_vs_mem%0d", name, n),
          32'(bus.Reg_Write & (bus.Mem_Read | bus.Mem_Write)), 32'd0);
      n++;
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ ||
           op == OP_J || op == OP_ADDI;
  endfunction

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(0, 3));
    if (r == 6) return int'($urandom_range(4, 14));
    if (r == 7) return TMO;
    return TMO + 1;
  endfunction

  initial begin
    //                  pcw pcwc iord mr mw irw m2r rw rd sa sb     op     ps     ex
    w_fetch_wait   = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    w_fetch_done   = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    w_fetch_to     = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1);
    w_decode       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
    w_mem_addr     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
    w_mem_read     = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    w_mem_read_to  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    w_mem_wb       = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    w_mem_write    = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    w_mem_write_to = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    w_r_exec       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
    w_r_wb         = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
    w_addi_exec    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
    w_addi_wb      = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    w_branch       = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
    w_jump         = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
    w_illegal      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);

    rst = 1'b1;
    bus.Opcode = 6'h00;
    bus.Mem_Ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("por_outs%0d", k), 32'(obs_word()), 32'd0);
      chk($sformatf("por_estado%0d", k), 32'(bus.Estado), 32'(ST_FETCH));
    end

    run_instr("sw_rst_mid_write", OP_SW, 0, 5, 5, 3);
    run_instr("rtype", OP_RTYPE, 0, 0, -1, 0);
    run_instr("lw_wait2", OP_LW, 0, 2, -1, 0);
    run_instr("beq", OP_BEQ, 0, 0, -1, 0);
    run_instr("j", OP_J, 0, 0, -1, 0);
    run_instr("illegal_3f", 6'h3F, 0, 0, -1, 0);
    run_instr("addi_fwait1", OP_ADDI, 1, 0, -1, 0);
    run_instr("sw_wait1", OP_SW, 0, 1, -1, 0);
    run_instr("fetch_timeout", OP_RTYPE, TMO + 1, 0, -1, 0);
    run_instr("fetch_ready_at_limit", OP_RTYPE, TMO, 0, -1, 0);
    run_instr("lw_read_timeout", OP_LW, 0, TMO + 1, -1, 0);
    run_instr("sw_write_timeout", OP_SW, 2, TMO + 1, -1, 0);
    run_instr("lw_ready_at_limit", OP_LW, 0, TMO, -1, 0);
    run_instr("rtype_rst_in_wb", OP_RTYPE, 0, 0, 3, 1);
    run_instr("lw_rst_in_wb", OP_LW, 0, 0, 4, 2);
    run_instr("addi_after_rst", OP_ADDI, 0, 0, -1, 0);

    for (int t = 0; t < 60; t++) begin
      logic [5:0] op;
      int sel;
      int rst_at;
      sel = int'($urandom_range(0, 6));
      case (sel)
        0: op = OP_RTYPE;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_J;
        5: op = OP_ADDI;
        default: begin
          op = 6'($urandom_range(0, 63));
          for (int g = 0; g < 64 && is_legal(op); g++) op = op + 6'd1;
        end
      endcase
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_instr($sformatf("rnd%0d_op%02h", t, op), op, rand_wait(), rand_wait(),
                rst_at, int'($urandom_range(1, 3)));
    end

    run_instr("final_rtype", OP_RTYPE, 0, 0, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
